exhaustive_vector_driver: RTL and testbench

- Sequential stimulus/response stage that wraps our combinational gate-level blocks. It sits upstream of a combinational DUT and drives every input combination in ascending binary order.
- It also sits downstream of that DUT: it samples the DUT outputs alongside a golden model's outputs and counts mismatches.
- It compresses the DUT responses into a 16-bit signature, so exhaustive truth-table checks run in hardware without a hand-written vector list.

---
 rtl/exhaustive_vector_driver_if.sv | 45 ++++
 rtl/exhaustive_vector_driver.sv | 159 +++++++++++++++
 tb/tb_exhaustive_vector_driver.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/exhaustive_vector_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : exhaustive_vector_driver_if
// Description : Bundle of the control, DUT-response and result signals of the
//               exhaustive vector driver.
//               master : the driver (drives vec and results, reads controls)
//               slave  : the environment (drives start/abort/dut_out/exp_out)
//               Signals:
//                 start, abort          sweep control
//                 dut_out, exp_out      DUT response and golden response
//                 vec, vec_valid        current stimulus vector
//                 busy, done            sweep status
//                 err_count, first_fail_vec, first_fail_valid, signature
// Revision    : 1.0 - initial release
// ============================================================================
interface exhaustive_vector_driver_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 3
);
    logic               start;
    logic               abort;
    logic [N_OUT-1:0]   dut_out;
    logic [N_OUT-1:0]   exp_out;
    logic [N_IN-1:0]    vec;
    logic               vec_valid;
    logic               busy;
    logic               done;
    logic [N_IN:0]      err_count;
    logic [N_IN-1:0]    first_fail_vec;
    logic               first_fail_valid;
    logic [15:0]        signature;

    modport master (
        input  start, abort, dut_out, exp_out,
        output vec, vec_valid, busy, done, err_count,
               first_fail_vec, first_fail_valid, signature
    );

    modport slave (
        output start, abort, dut_out, exp_out,
        input  vec, vec_valid, busy, done, err_count,
               first_fail_vec, first_fail_valid, signature
    );
endinterface
`default_nettype wire

// File: rtl/exhaustive_vector_driver.sv
`default_nettype none
// ============================================================================
// Module      : exhaustive_vector_driver
// Description : Drives every N_IN-bit input combination of a combinational
//               DUT in ascending order, holding each vector SETTLE+1 cycles.
//               On the last cycle of each vector it compares dut_out against
//               exp_out, counts mismatching vectors, records the first
//               failing vector and folds dut_out into a 16-bit MISR.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-high reset
//               bus  - exhaustive_vector_driver_if.master (start, abort,
//                      dut_out, exp_out in; vec, vec_valid, busy, done,
//                      err_count, first_fail_vec, first_fail_valid,
//                      signature out)
// Revision    : 1.0 - initial release
// ============================================================================
module exhaustive_vector_driver #(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 3,
    parameter int SETTLE = 1
) (
    input  wire                           clk,
    input  wire                           rst,
    exhaustive_vector_driver_if.master    bus
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_HOLD   = 2'd1;
    localparam logic [1:0] c_SAMPLE = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    localparam logic [3:0]    c_SETTLE  = 4'(SETTLE);
    localparam logic [3:0]    c_HOLD_LAST = 4'd1;
    localparam logic [N_IN-1:0] c_VEC_ONE = {{(N_IN-1){1'b0}}, 1'b1};
    localparam logic [N_IN-1:0] c_VEC_LAST = {N_IN{1'b1}};
    localparam logic [N_IN:0]   c_ERR_ONE = {{N_IN{1'b0}}, 1'b1};
    localparam logic [15:0]   c_POLY    = 16'h1021;

    logic [1:0]         r_state;
    logic [3:0]         r_hold;
    logic [N_IN-1:0]    r_vec;
    logic               r_vec_valid;
    logic               r_busy;
    logic               r_done;
    logic [N_IN:0]      r_err;
    logic [N_IN-1:0]    r_ffv;
    logic               r_ffvalid;
    logic [15:0]        r_sig;

    logic [15:0]        w_dut_ext;
    logic [15:0]        w_sig_next;
    logic               w_mismatch;
    logic               w_last;

    // dut_out is zero-extended into the low bits of the MISR input word.
    always_comb begin
        w_dut_ext                = '0;
        w_dut_ext[N_OUT-1:0]     = bus.dut_out;
        w_sig_next               = {r_sig[14:0], 1'b0}
                                 ^ (r_sig[15] ? c_POLY : 16'h0000)
                                 ^ w_dut_ext;
        w_mismatch               = (bus.dut_out != bus.exp_out);
        w_last                   = (r_vec == c_VEC_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_hold      <= '0;
            r_vec       <= '0;
            r_vec_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= '0;
            r_ffv       <= '0;
            r_ffvalid   <= 1'b0;
            r_sig       <= '0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    // abort wins over start; in DONE it also drops done.
                    if (bus.abort) begin
                        r_state <= c_IDLE;
                        r_done  <= 1'b0;
                    end else if (bus.start) begin
                        r_state     <= c_HOLD;
                        r_hold      <= c_SETTLE;
                        r_vec       <= '0;
                        r_vec_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_err       <= '0;
                        r_ffv       <= '0;
                        r_ffvalid   <= 1'b0;
                        r_sig       <= '0;
                    end
                end

                c_HOLD: begin
                    if (bus.abort) begin
                        r_state     <= c_IDLE;
                        r_vec_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b0;
                    end else if (r_hold == c_HOLD_LAST) begin
                        r_state <= c_SAMPLE;
                    end else begin
                        r_hold <= r_hold - c_HOLD_LAST;
                    end
                end

                c_SAMPLE: begin
                    // An abort here discards this vector's response entirely.
                    if (bus.abort) begin
                        r_state     <= c_IDLE;
                        r_vec_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b0;
                    end else begin
                        r_sig <= w_sig_next;
                        if (w_mismatch) begin
                            r_err <= r_err + c_ERR_ONE;
                            if (!r_ffvalid) begin
                                r_ffv     <= r_vec;
                                r_ffvalid <= 1'b1;
                            end
                        end
                        if (w_last) begin
                            // vec keeps the final vector for inspection.
                            r_state     <= c_DONE;
                            r_vec_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_state <= c_HOLD;
                            r_hold  <= c_SETTLE;
                            r_vec   <= r_vec + c_VEC_ONE;
                        end
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.vec              = r_vec;
    assign bus.vec_valid        = r_vec_valid;
    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
    assign bus.err_count        = r_err;
    assign bus.first_fail_vec   = r_ffv;
    assign bus.first_fail_valid = r_ffvalid;
    assign bus.signature        = r_sig;

endmodule
`default_nettype wire

// File: tb/tb_exhaustive_vector_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_exhaustive_vector_driver
// Description : Self-checking bench for exhaustive_vector_driver. Two
//               instances: A (N_IN=2, N_OUT=1, SETTLE=1, DUT=XOR) and
//               B (N_IN=4, N_OUT=3, SETTLE=3, DUT=fb()). A queue holds the
//               expected vec for every valid cycle; a table holds the
//               expected end-of-sweep results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exhaustive_vector_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          sel = 0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        a_and = 1'b0;
    logic [15:0] b_mask = 16'h0000;

    int checks = 0;
    int failures = 0;
    int q[$];

    always #5 clk = ~clk;

    exhaustive_vector_driver_if #(.N_IN(2), .N_OUT(1)) bus_a ();
    exhaustive_vector_driver_if #(.N_IN(4), .N_OUT(3)) bus_b ();

    exhaustive_vector_driver #(.N_IN(2), .N_OUT(1), .SETTLE(1)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    exhaustive_vector_driver #(.N_IN(4), .N_OUT(3), .SETTLE(3)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );

    function automatic logic [2:0] fb(input logic [3:0] v);
        return {v[3] ^ v[0], v[2] & v[1], ~v[1] ^ v[2]};
    endfunction

    // Signature after the first n vectors of instance B.
    function automatic logic [15:0] sig_b(input int n);
        logic [15:0] s;
        logic [3:0]  v;
        s = 16'h0000;
        for (int i = 0; i < n; i++) begin
            v = 4'(i);
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {13'b0, fb(v)};
        end
        return s;
    endfunction

    // Combinational DUTs and golden models, plus routing of start/abort.
    always_comb begin
        bus_a.start   = start && (sel == 0);
        bus_a.abort   = abort && (sel == 0);
        bus_b.start   = start && (sel == 1);
        bus_b.abort   = abort && (sel == 1);
        bus_a.dut_out = ^bus_a.vec;
        bus_a.exp_out = a_and ? &bus_a.vec : ^bus_a.vec;
        bus_b.dut_out = fb(bus_b.vec);
        bus_b.exp_out = fb(bus_b.vec) ^ {2'b00, b_mask[bus_b.vec]};
    end

    logic [3:0]  cur_vec, cur_ffv;
    logic [4:0]  cur_err;
    logic [15:0] cur_sig;
    logic        cur_vv, cur_busy, cur_done, cur_ffvalid;

    always_comb begin
        if (sel == 1) begin
            cur_vec = bus_b.vec;             cur_ffv = bus_b.first_fail_vec;
            cur_err = bus_b.err_count;       cur_sig = bus_b.signature;
            cur_vv  = bus_b.vec_valid;       cur_busy = bus_b.busy;
            cur_done = bus_b.done;           cur_ffvalid = bus_b.first_fail_valid;
        end else begin
            cur_vec = {2'b00, bus_a.vec};    cur_ffv = {2'b00, bus_a.first_fail_vec};
            cur_err = {2'b00, bus_a.err_count}; cur_sig = bus_a.signature;
            cur_vv  = bus_a.vec_valid;       cur_busy = bus_a.busy;
            cur_done = bus_a.done;           cur_ffvalid = bus_a.first_fail_valid;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every valid cycle pops the expected vector.
    always @(negedge clk) begin
        if (!rst && cur_vv) begin
            if (q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                chk("sb_vec", 32'(cur_vec), 32'(q.pop_front()));
            end
        end
    end

    task automatic run_sweep(input int inject_k);
        int nv, s1, d;
        nv = (sel == 1) ? 16 : 4;
        s1 = (sel == 1) ? 4 : 2;
        d  = nv * s1;
        @(negedge clk);
        start = 1'b1;
        for (int v = 0; v < nv; v++)
            for (int r = 0; r < s1; r++) q.push_back(v);
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 32'(cur_busy), 32'd1);
        chk("start_vv", 32'(cur_vv), 32'd1);
        chk("start_done", 32'(cur_done), 32'd0);
        chk("start_err_clr", 32'(cur_err), 32'd0);
        chk("start_ffvalid_clr", 32'(cur_ffvalid), 32'd0);
        chk("start_sig_clr", 32'(cur_sig), 32'd0);
        for (int k = 1; k <= d; k++) begin
            @(negedge clk);
            start = (k == inject_k);
            if (k == 1)     chk("done_low_e1", 32'(cur_done), 32'd0);
            if (k == d - 1) chk("done_low_early", 32'(cur_done), 32'd0);
            if (k == d) begin
                chk("done_high", 32'(cur_done), 32'd1);
                chk("done_busy", 32'(cur_busy), 32'd0);
                chk("done_vv", 32'(cur_vv), 32'd0);
                chk("done_vec_last", 32'(cur_vec), 32'(nv - 1));
            end
        end
        start = 1'b0;
        chk("sb_drain", 32'(q.size()), 32'd0);
    endtask

    task automatic run_abort(input logic [15:0] mask, input int abort_k,
                             input int e_err, input int e_ffv, input int e_ffvalid,
                             input logic [15:0] e_sig);
        sel = 1;
        b_mask = mask;
        @(negedge clk);
        start = 1'b1;
        for (int v = 0; v < 16; v++)
            for (int r = 0; r < 4; r++) q.push_back(v);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= abort_k; k++) begin
            @(negedge clk);
            abort = (k == abort_k);
        end
        @(negedge clk);
        abort = 1'b0;
        q.delete();
        chk("abort_busy", 32'(cur_busy), 32'd0);
        chk("abort_vv", 32'(cur_vv), 32'd0);
        chk("abort_done", 32'(cur_done), 32'd0);
        chk("abort_err", 32'(cur_err), 32'(e_err));
        chk("abort_ffv", 32'(cur_ffv), 32'(e_ffv));
        chk("abort_ffvalid", 32'(cur_ffvalid), 32'(e_ffvalid));
        chk("abort_sig", 32'(cur_sig), 32'(e_sig));
        repeat (3) @(negedge clk);
        chk("abort_stay_idle", 32'(cur_busy), 32'd0);
    endtask

    typedef struct {
        int          sel;
        logic        gand;
        logic [15:0] mask;
        int          err;
        int          ffv;
        int          ffvalid;
        logic [15:0] sig;
    } vec_case_t;

    vec_case_t cases[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        cases[0] = '{0, 1'b0, 16'h0000, 0, 0, 0, 16'h0006};
        cases[1] = '{0, 1'b1, 16'h0000, 3, 1, 1, 16'h0006};
        cases[2] = '{1, 1'b0, 16'h0000, 0, 0, 0, sig_b(16)};
        cases[3] = '{1, 1'b0, 16'h0884, 3, 2, 1, sig_b(16)};
        cases[4] = '{1, 1'b0, 16'h8000, 1, 15, 1, sig_b(16)};
        cases[5] = '{1, 1'b0, 16'h0001, 1, 0, 1, sig_b(16)};

        // Reset state of both instances.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            chk("rst_vec", 32'(cur_vec), 32'd0);
            chk("rst_busy", 32'(cur_busy), 32'd0);
            chk("rst_done", 32'(cur_done), 32'd0);
            chk("rst_sig", 32'(cur_sig), 32'd0);
        end

        // Table-driven full sweeps; consecutive B cases restart from DONE.
        for (int i = 0; i < 6; i++) begin
            sel    = cases[i].sel;
            a_and  = cases[i].gand;
            b_mask = cases[i].mask;
            run_sweep(0);
            chk("tbl_err", 32'(cur_err), 32'(cases[i].err));
            chk("tbl_ffv", 32'(cur_ffv), 32'(cases[i].ffv));
            chk("tbl_ffvalid", 32'(cur_ffvalid), 32'(cases[i].ffvalid));
            chk("tbl_sig", 32'(cur_sig), 32'(cases[i].sig));
        end

        // start while busy (vector 3 of B) must be ignored.
        sel = 1;
        b_mask = 16'h0000;
        run_sweep(13);
        chk("inject_err", 32'(cur_err), 32'd0);
        chk("inject_sig", 32'(cur_sig), 32'(sig_b(16)));

        // abort in HOLD of vector 5; mismatches on 2 and 7.
        run_abort(16'h0084, 21, 1, 2, 1, sig_b(5));
        // abort coincident with the SAMPLE cycle of mismatching vector 7.
        run_abort(16'h0080, 31, 0, 0, 0, sig_b(7));

        // abort in DONE returns to IDLE; start+abort in IDLE is ignored.
        sel = 0;
        a_and = 1'b0;
        run_sweep(0);
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("done_abort_done", 32'(cur_done), 32'd0);
        chk("done_abort_busy", 32'(cur_busy), 32'd0);
        chk("done_abort_sig_kept", 32'(cur_sig), 32'h0006);
        @(negedge clk); abort = 1'b1; start = 1'b1;
        @(negedge clk); abort = 1'b0; start = 1'b0;
        chk("idle_abort_start_busy", 32'(cur_busy), 32'd0);
        chk("idle_abort_start_vv", 32'(cur_vv), 32'd0);

        // Asynchronous reset mid-sweep, between clock edges.
        sel = 1;
        b_mask = 16'h0002;
        @(negedge clk);
        start = 1'b1;
        for (int v = 0; v < 16; v++)
            for (int r = 0; r < 4; r++) q.push_back(v);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_rst_err", 32'(cur_err), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_vec", 32'(cur_vec), 32'd0);
        chk("arst_vv", 32'(cur_vv), 32'd0);
        chk("arst_busy", 32'(cur_busy), 32'd0);
        chk("arst_done", 32'(cur_done), 32'd0);
        chk("arst_err", 32'(cur_err), 32'd0);
        chk("arst_ffvalid", 32'(cur_ffvalid), 32'd0);
        chk("arst_ffv", 32'(cur_ffv), 32'd0);
        chk("arst_sig", 32'(cur_sig), 32'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_busy", 32'(cur_busy), 32'd0);
        chk("post_rst_vv", 32'(cur_vv), 32'd0);
        chk("post_rst_done", 32'(cur_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
